// File: rtl/rr_mux_sel_sequencer_if.sv
// Bundle between the select sequencer, its requesters and the 3:1 mux.
// master: sequencer side (drives sel/grant/busy/y_q/y_valid); slave: the rest.
interface rr_mux_sel_sequencer_if #(
  parameter int W = 2
);
  logic [2:0]   req;
  logic [W-1:0] y_in;
  logic [1:0]   sel;
  logic [2:0]   grant;
  logic         busy;
  logic [W-1:0] y_q;
  logic         y_valid;

  modport master (
    input  req,
    input  y_in,
    output sel,
    output grant,
    output busy,
    output y_q,
    output y_valid
  );

  modport slave (
    output req,
    output y_in,
    input  sel,
    input  grant,
    input  busy,
    input  y_q,
    input  y_valid
  );
endinterface

// File: rtl/rr_mux_sel_sequencer.sv
// Round-robin sel sequencer for a 3:1 mux; each grant dwells DWELL cycles.
// Ports: clk, rst_n (async low), bus (req/y_in in; sel/grant/busy/y_q/y_valid out).
module rr_mux_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rr_mux_sel_sequencer_if.master bus
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    last_q, last_d;
  logic [2:0]    grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  ycap_q, ycap_d;
  logic          vld_q, vld_d;

  logic [1:0]    c1, c2, win;
  logic          found;
  logic          arb;

  // next channel in rotation; code 11 folds back to channel 0
  function automatic logic [1:0] nxt(input logic [1:0] i);
    logic [1:0] r;
    r = 2'b00;
    unique case (i)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic req_at(
    input logic [2:0] r,
    input logic [1:0] i
  );
    logic b;
    b = 1'b0;
    unique case (i)
      2'b00:   b = r[0];
      2'b01:   b = r[1];
      2'b10:   b = r[2];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    logic [2:0] o;
    o = 3'b000;
    unique case (i)
      2'b00:   o = 3'b001;
      2'b01:   o = 3'b010;
      2'b10:   o = 3'b100;
      default: o = 3'b000;
    endcase
    return o;
  endfunction

  // scan last+1, last+2, last
  always_comb begin
    c1    = nxt(last_q);
    c2    = nxt(c1);
    found = 1'b1;
    win   = c1;
    if (req_at(bus.req, c1)) begin
      win = c1;
    end else if (req_at(bus.req, c2)) begin
      win = c2;
    end else if (req_at(bus.req, last_q)) begin
      win = last_q;
    end else begin
      found = 1'b0;
      win   = last_q;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ycap_d  = ycap_q;
    vld_d   = 1'b0;
    arb     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req != 3'b000) begin
          arb = 1'b1;
        end
      end
      GRANT: begin
        if (!req_at(bus.req, sel_q)) begin
          // abort: requester left, nothing captured
          arb = 1'b1;
        end else if (cnt_q == '0) begin
          ycap_d = bus.y_in;
          vld_d  = 1'b1;
          arb    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase

    if (arb) begin
      if (found) begin
        state_d = GRANT;
        sel_d   = win;
        last_d  = win;
        grant_d = onehot(win);
        cnt_d   = CNT_LOAD;
      end else begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    end

    // keep the mux off its unused code
    if (sel_d == 2'b11) begin
      sel_d = 2'b00;
    end
    if (last_d == 2'b11) begin
      last_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      last_q  <= 2'b10;
      grant_q <= 3'b000;
      cnt_q   <= '0;
      ycap_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ycap_q  <= ycap_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = (state_q == GRANT);
  assign bus.y_q     = ycap_q;
  assign bus.y_valid = vld_q;

endmodule

// File: tb/tb_rr_mux_sel_sequencer.sv
// Bench for rr_mux_sel_sequencer: DWELL=4 and DWELL=1 instances.
// Captured y values are checked against a queue of expected results.
module tb_rr_mux_sel_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_mux_sel_sequencer_if #(.W(2)) bus0 ();
  rr_mux_sel_sequencer_if #(.W(2)) bus1 ();

  function automatic logic [1:0] mux(input logic [1:0] s);
    logic [1:0] y;
    case (s)
      2'b00:   y = 2'b00;
      2'b01:   y = 2'b01;
      2'b10:   y = 2'b10;
      default: y = 2'b11;
    endcase
    return y;
  endfunction

  assign bus0.y_in = mux(bus0.sel);
  assign bus1.y_in = mux(bus1.sel);

  rr_mux_sel_sequencer #(.DWELL(4), .W(2)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  rr_mux_sel_sequencer #(.DWELL(1), .W(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] exp0[$];
  logic [1:0] exp1[$];

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && bus0.y_valid) begin
      checks++;
      if (exp0.size() == 0) begin
        errors++;
        $display("FAIL y0_unexpected: y_q=%b pulsed, none required", bus0.y_q);
      end else begin
        e = exp0.pop_front();
        if (bus0.y_q !== e) begin
          errors++;
          $display("FAIL y0_value: got %b want %b", bus0.y_q, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && bus1.y_valid) begin
      checks++;
      if (exp1.size() == 0) begin
        errors++;
        $display("FAIL y1_unexpected: y_q=%b pulsed, none required", bus1.y_q);
      end else begin
        e = exp1.pop_front();
        if (bus1.y_q !== e) begin
          errors++;
          $display("FAIL y1_value: got %b want %b", bus1.y_q, e);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus0.req = 3'b000;
    bus1.req = 3'b000;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] o;
    rst_n = 1'b0;
    bus0.req = 3'b000;
    bus1.req = 3'b000;
    #3;
    o = {bus0.sel, bus0.grant, bus0.busy, bus0.y_valid};
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: outputs=%b want 00000000", o);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      o = {bus0.sel, bus0.grant, bus0.busy, bus0.y_valid};
      checks++;
      if (o !== 8'h00 || bus0.y_q !== 2'b00) begin
        errors++;
        $display("FAIL idle_c%0d: outputs=%b y_q=%b want 0", i, o, bus0.y_q);
      end
    end
  endtask

  task automatic test_single;
    do_reset();
    exp0.push_back(2'b01);
    exp0.push_back(2'b01);
    bus0.req = 3'b010;
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++;
      if (bus0.sel !== 2'b01 || bus0.grant !== 3'b010 || bus0.busy !== 1'b1) begin
        errors++;
        $display("FAIL single_c%0d: sel=%b grant=%b busy=%b want 01 010 1",
                 i, bus0.sel, bus0.grant, bus0.busy);
      end
      if (i == 5) begin
        checks++;
        if (bus0.y_valid !== 1'b1 || bus0.y_q !== 2'b01) begin
          errors++;
          $display("FAIL single_pulse: y_valid=%b y_q=%b want 1 01",
                   bus0.y_valid, bus0.y_q);
        end
      end
      if (i == 6) begin
        checks++;
        if (bus0.y_valid !== 1'b0) begin
          errors++;
          $display("FAIL single_pulse_len: y_valid=%b want 0", bus0.y_valid);
        end
      end
    end
    bus0.req = 3'b000;
    step();
    checks++;
    if (bus0.busy !== 1'b0 || bus0.grant !== 3'b000 || bus0.sel !== 2'b01) begin
      errors++;
      $display("FAIL single_idle: busy=%b grant=%b sel=%b want 0 000 01",
               bus0.busy, bus0.grant, bus0.sel);
    end
    checks++;
    if (exp0.size() != 0) begin
      errors++;
      $display("FAIL single_missing: %0d pulses outstanding, want 0", exp0.size());
      exp0.delete();
    end
  endtask

  task automatic test_rotation;
    logic [1:0] es;
    do_reset();
    exp0.push_back(2'b00);
    exp0.push_back(2'b01);
    exp0.push_back(2'b10);
    bus0.req = 3'b111;
    for (int i = 1; i <= 13; i++) begin
      step();
      es = 2'(((i - 1) / 4) % 3);
      checks++;
      if (bus0.sel !== es || bus0.grant !== (3'b001 << es) || bus0.busy !== 1'b1) begin
        errors++;
        $display("FAIL rot_c%0d: sel=%b grant=%b busy=%b want sel %b",
                 i, bus0.sel, bus0.grant, bus0.busy, es);
      end
    end
    bus0.req = 3'b000;
    step();
    checks++;
    if (bus0.busy !== 1'b0) begin
      errors++;
      $display("FAIL rot_idle: busy=%b want 0", bus0.busy);
    end
    step();
    checks++;
    if (exp0.size() != 0) begin
      errors++;
      $display("FAIL rot_missing: %0d pulses outstanding, want 0", exp0.size());
      exp0.delete();
    end
  endtask

  task automatic test_early_release;
    bus0.req = 3'b100;
    step();
    checks++;
    if (bus0.sel !== 2'b10 || bus0.grant !== 3'b100) begin
      errors++;
      $display("FAIL early_grant: sel=%b grant=%b want 10 100", bus0.sel, bus0.grant);
    end
    step();
    bus0.req = 3'b001;
    step();
    checks++;
    if (bus0.sel !== 2'b00 || bus0.grant !== 3'b001 || bus0.y_valid !== 1'b0
        || bus0.y_q !== 2'b10) begin
      errors++;
      $display("FAIL early_abort: sel=%b grant=%b y_valid=%b y_q=%b want 00 001 0 10",
               bus0.sel, bus0.grant, bus0.y_valid, bus0.y_q);
    end
    bus0.req = 3'b000;
    step();
    checks++;
    if (bus0.busy !== 1'b0 || exp0.size() != 0) begin
      errors++;
      $display("FAIL early_idle: busy=%b pending=%0d want 0 0", bus0.busy, exp0.size());
      exp0.delete();
    end
  endtask

  task automatic test_reset_mid_grant;
    logic [9:0] o;
    bus0.req = 3'b010;
    step();
    step();
    step();
    checks++;
    if (bus0.sel !== 2'b01 || bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: sel=%b busy=%b want 01 1", bus0.sel, bus0.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    o = {bus0.sel, bus0.grant, bus0.busy, bus0.y_valid, bus0.y_q, 2'b00};
    checks++;
    if (o !== 10'h000) begin
      errors++;
      $display("FAIL mid_async: sel/grant/busy/vld/y_q=%b want all 0", o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus0.req = 3'b111;
    step();
    checks++;
    if (bus0.sel !== 2'b00 || bus0.grant !== 3'b001) begin
      errors++;
      $display("FAIL mid_first: sel=%b grant=%b want 00 001", bus0.sel, bus0.grant);
    end
    bus0.req = 3'b000;
    step();
    checks++;
    if (bus0.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: busy=%b want 0", bus0.busy);
    end
  endtask

  task automatic test_dwell1;
    logic [1:0] es;
    do_reset();
    for (int i = 2; i <= 8; i++) begin
      exp1.push_back(((i - 1) % 2 == 1) ? 2'b00 : 2'b10);
    end
    bus1.req = 3'b101;
    for (int i = 1; i <= 8; i++) begin
      step();
      es = (i % 2 == 1) ? 2'b00 : 2'b10;
      checks++;
      if (bus1.sel !== es || bus1.busy !== 1'b1) begin
        errors++;
        $display("FAIL d1_c%0d: sel=%b busy=%b want %b 1", i, bus1.sel, bus1.busy, es);
      end
      if (i >= 2) begin
        checks++;
        if (bus1.y_valid !== 1'b1) begin
          errors++;
          $display("FAIL d1_vld_c%0d: y_valid=%b want 1", i, bus1.y_valid);
        end
      end
    end
    bus1.req = 3'b000;
    step();
    checks++;
    if (bus1.busy !== 1'b0 || bus1.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL d1_idle: busy=%b y_valid=%b want 0 0", bus1.busy, bus1.y_valid);
    end
    step();
    checks++;
    if (exp1.size() != 0) begin
      errors++;
      $display("FAIL d1_missing: %0d pulses outstanding, want 0", exp1.size());
      exp1.delete();
    end
  endtask

  initial begin
    bus0.req = 3'b000;
    bus1.req = 3'b000;
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_reset_mid_grant();
    test_dwell1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
